dffram_arbiter: RTL and testbench
=================================

// Module: dffram_arbiter
// PURPOSE
//   Shares the single-port 512x32 DFFRAM mesh store between NREQ requesters
//   (vertex fetch, subdivision writer, host load/dump).
//   - Round-robin arbitration, one RAM access per cycle.
//   - Optional lock: an owner holds the RAM for a burst, e.g. 3 vertices of a face.
//   - Each granted read returns its data one cycle later, tagged to that requester.
// PARAMETERS
//   NREQ    2   number of requesters, 2..4
//   A_W     9   RAM address width (512 words)
//   D_W     32  RAM data width, 4 byte lanes
// PORTS
//   CLK       in   1         clock, all state on rising edge
//   RST_N     in   1         asynchronous active-low reset
//   req       in   NREQ      per-requester access request
//   lock      in   NREQ      hold grant after this access (burst)
//   we        in   NREQ*4    byte write enables; slice i = we[4i+3:4i]; 0 = read
//   addr      in   NREQ*A_W  word address; slice i = addr[A_W*i +: A_W]
//   wdata     in   NREQ*D_W  write data; slice i = wdata[D_W*i +: D_W]
//   gnt       out  NREQ      one-hot grant, combinational, same cycle as req
//   rvalid    out  NREQ      one-hot read-data valid
//   rdata     out  D_W       read data, broadcast; qualified by rvalid
//   ram_en    out  1         to RAM EN0
//   ram_we    out  4         to RAM WE0
//   ram_a     out  A_W       to RAM A0
//   ram_di    out  D_W       to RAM Di0
//   ram_do    in   D_W       from RAM Do0 (registered in RAM)
// BEHAVIOUR
//   - Handshake: requester holds req/we/addr/wdata stable until it sees gnt.
//     A transfer happens in any cycle where req[i] & gnt[i].
//   - Grant is combinational:
//     - At most one gnt bit high, and only if the matching req bit is high.
//     - While RST_N is low, gnt=0.
//   - RAM drive:
//     - ram_en = |gnt.
//     - ram_we/ram_a/ram_di are muxed from the granted slice.
//     - When nothing is granted: ram_we=0, ram_a=0, ram_di=0.
//   - Round robin:
//     - Registered pointer ptr, in 0..NREQ-1, reset value 0.
//     - Search order is ptr, ptr+1, ... (mod NREQ); first requester found wins.
//     - After an unlocked transfer by i, ptr <= (i+1) mod NREQ.
//     - With no transfer, ptr holds.
//   - FSM, 2 states:
//     - OPEN: normal round robin.
//       - A transfer by i with lock[i]=1 -> LOCKED, owner <= i, ptr unchanged.
//     - LOCKED: only owner can be granted; all other req are stalled.
//       - Owner transfer with lock[owner]=0 -> OPEN, ptr <= owner+1.
//       - Owner with req=0 and lock=0 in a cycle -> OPEN, ptr <= owner+1.
//       - Owner holding lock=1 with req=0 keeps the lock; other requesters stay stalled.
//   - Read return:
//     - A read transfer (we slice == 0) by i in cycle N gives rvalid[i]=1 in
//       cycle N+1, with rdata = ram_do.
//     - Data is the word before any write in cycle N.
//     - Writes produce no rvalid.
//     - Reads are back-to-back capable: 1 per cycle, in order.
//   - rdata = ram_do when any rvalid bit is high, else 0.
//   - Read-after-write to the same address in consecutive cycles returns the new data.
//   - Reset values: state=OPEN, owner=0, ptr=0, rvalid=0. Combinational outputs
//     (gnt, ram_en, ram_we, ram_a, ram_di) read 0 during reset.
//   - Reset mid-operation:
//     - Asynchronously clears state; a pending rvalid is dropped.
//     - Any lock is released.
//     - The RAM contents are untouched.
//   - Out-of-range owner/ptr values cannot occur and need no handling.
// TESTING
//   - Single read: req[0]=1, we=0, addr=9'h005 -> gnt[0] same cycle; next cycle
//     rvalid=2'b01, rdata = word 5 of icosahedron.hex.
//   - Contention: req=2'b11 held 4 cycles, both reads, ptr=0 -> gnt order 01,10,01,10;
//     each rvalid follows its grant by 1 cycle.
//   - Byte write then read: req1 we=4'b0010, addr=3, wdata=32'h0000AB00;
//     next cycle req1 reads addr 3 -> bits[15:8]=8'hAB, other bytes unchanged.
//   - Lock burst: req0 reads addr 10,11,12 with lock=1,1,0 while req1 held high
//     -> gnt0 x3 consecutively, then gnt1; FSM LOCKED->OPEN after the third read.
//   - Owner abandon: lock0=1 then req0=lock0=0 for a cycle -> FSM returns to OPEN;
//     a waiting req1 is granted in the same cycle.
//   - Reset mid-read: RST_N low in the cycle after a read grant -> rvalid=0
//     immediately; after release ptr=0, OPEN, first grant goes to req0.

Source files
------------

// File: rtl/dffram_arbiter_if.sv
// Bundle of every signal between the arbiter, its requesters and the DFFRAM.
//   Requester side : req, lock, we, addr, wdata (to arbiter);
//                    gnt, rvalid, rdata (from arbiter)
//   RAM side       : ram_en, ram_we, ram_a, ram_di (to RAM); ram_do (from RAM)
// Handshake: a requester holds req/lock/we/addr/wdata stable until it sees
// gnt; a transfer happens in every cycle where req[i] & gnt[i]. A read
// transfer in cycle N answers with rvalid[i] (and rdata) in cycle N+1.
interface dffram_arbiter_if #(
  parameter int NREQ = 2,
  parameter int A_W  = 9,
  parameter int D_W  = 32
);
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     lock;
  logic [NREQ*4-1:0]   we;
  logic [NREQ*A_W-1:0] addr;
  logic [NREQ*D_W-1:0] wdata;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rvalid;
  logic [D_W-1:0]      rdata;
  logic                ram_en;
  logic [3:0]          ram_we;
  logic [A_W-1:0]      ram_a;
  logic [D_W-1:0]      ram_di;
  logic [D_W-1:0]      ram_do;

  // Arbiter view.
  modport slave (
    input  req, lock, we, addr, wdata, ram_do,
    output gnt, rvalid, rdata, ram_en, ram_we, ram_a, ram_di
  );

  // Requesters plus RAM, seen from outside the arbiter.
  modport master (
    output req, lock, we, addr, wdata, ram_do,
    input  gnt, rvalid, rdata, ram_en, ram_we, ram_a, ram_di
  );
endinterface

// File: rtl/dffram_arbiter.sv
// Round-robin arbiter sharing one single-port 512x32 DFFRAM between NREQ
// requesters, with optional burst lock and tagged one-cycle read return.
//   CLK          : clock, all state on rising edge
//   RST_N        : asynchronous active-low reset
//   bus          : dffram_arbiter_if.slave (requester + RAM signals)
//   dbg_locked_o : FSM state, 1 = LOCKED, 0 = OPEN
module dffram_arbiter #(
  parameter int NREQ = 2,
  parameter int A_W  = 9,
  parameter int D_W  = 32
) (
  input  logic                CLK,
  input  logic                RST_N,
  dffram_arbiter_if.slave     bus,
  output logic                dbg_locked_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;

  logic [PW-1:0]   win;
  logic [PW-1:0]   start;
  logic            xfer;
  logic            open_arb;
  logic [NREQ-1:0] gnt;
  logic [3:0]      we_sel;
  logic [A_W-1:0]  a_sel;
  logic [D_W-1:0]  d_sel;

  function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] x);
    if (int'(x) == NREQ - 1) return '0;
    return x + 1'b1;
  endfunction

  // Arbitration. An owner that drops both req and lock opens the arbiter in
  // the same cycle, with the search starting just after the owner, so a
  // waiting requester is served without a dead cycle.
  always_comb begin
    int idx;
    win      = '0;
    xfer     = 1'b0;
    idx      = 0;
    open_arb = (state_q == ST_OPEN) || (!bus.req[owner_q] && !bus.lock[owner_q]);
    start    = (state_q == ST_OPEN) ? ptr_q : inc_wrap(owner_q);
    if (RST_N) begin
      if (open_arb) begin
        // Walk the search order backwards so the nearest requester is the
        // last one written and therefore wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
          idx = int'(start) + k;
          if (idx >= NREQ) idx = idx - NREQ;
          if (bus.req[idx]) begin
            win  = PW'(idx);
            xfer = 1'b1;
          end
        end
      end else if (bus.req[owner_q]) begin
        win  = owner_q;
        xfer = 1'b1;
      end
    end
  end

  // Grant and RAM drive, all zero when nothing is granted.
  always_comb begin
    gnt    = '0;
    we_sel = '0;
    a_sel  = '0;
    d_sel  = '0;
    if (xfer) begin
      gnt[win] = 1'b1;
      we_sel   = bus.we[4*int'(win) +: 4];
      a_sel    = bus.addr[A_W*int'(win) +: A_W];
      d_sel    = bus.wdata[D_W*int'(win) +: D_W];
    end
  end

  // Next state: FSM, pointer, owner and read-return tag.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    rvalid_d = (xfer && (we_sel == 4'b0000)) ? gnt : '0;
    if (xfer) begin
      if (bus.lock[win]) begin
        state_d = ST_LOCKED;
        owner_d = win;
      end else begin
        state_d = ST_OPEN;
        ptr_d   = inc_wrap(win);
      end
    end else if ((state_q == ST_LOCKED) && open_arb) begin
      state_d = ST_OPEN;
      ptr_d   = inc_wrap(owner_q);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_OPEN;
      ptr_q    <= '0;
      owner_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.gnt      = gnt;
  assign bus.ram_en   = xfer;
  assign bus.ram_we   = we_sel;
  assign bus.ram_a    = a_sel;
  assign bus.ram_di   = d_sel;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = (|rvalid_q) ? bus.ram_do : '0;
  assign dbg_locked_o = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_dffram_arbiter.sv
module tb_dffram_arbiter;
  localparam int NREQ  = 2;
  localparam int A_W   = 9;
  localparam int D_W   = 32;
  localparam int DEPTH = 512;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic dbg_locked;

  dffram_arbiter_if #(.NREQ(NREQ), .A_W(A_W), .D_W(D_W)) bus();

  dffram_arbiter #(.NREQ(NREQ), .A_W(A_W), .D_W(D_W)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .bus          (bus.slave),
    .dbg_locked_o (dbg_locked)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  // ---------------- DFFRAM model (registered output) ----------------
  logic [D_W-1:0] ram_mem [DEPTH];
  always @(posedge CLK) begin
    if (bus.ram_en) begin
      bus.ram_do <= ram_mem[bus.ram_a];
      for (int b = 0; b < 4; b++)
        if (bus.ram_we[b]) ram_mem[bus.ram_a][8*b +: 8] <= bus.ram_di[8*b +: 8];
    end
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    int             tag;
    logic [D_W-1:0] data;
    int unsigned    due;
  } exp_t;
  exp_t exp_q[$];

  logic [D_W-1:0] ref_mem [DEPTH];
  int  m_ptr = 0;
  int  m_owner = 0;
  bit  m_locked = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: arbitration + RAM ----------------
  always @(negedge CLK) begin
    int start, win, j;
    bit open;
    logic [3:0]     e_we;
    logic [A_W-1:0] e_a;
    logic [D_W-1:0] e_d;
    if (!RST_N) begin
      m_ptr = 0; m_owner = 0; m_locked = 1'b0;
      exp_q.delete();
      check("gnt_in_reset", bus.gnt, 0);
      check("ram_en_in_reset", bus.ram_en, 0);
      check("ram_bus_in_reset", {bus.ram_we, bus.ram_a, bus.ram_di}, 0);
      check("locked_in_reset", dbg_locked, 0);
    end else begin
      open  = !m_locked || (!bus.req[m_owner] && !bus.lock[m_owner]);
      start = m_locked ? (m_owner + 1) % NREQ : m_ptr;
      win   = -1;
      if (open) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (start + k) % NREQ;
          if (win < 0 && bus.req[j]) win = j;
        end
      end else if (bus.req[m_owner]) begin
        win = m_owner;
      end
      e_we = '0; e_a = '0; e_d = '0;
      if (win >= 0) begin
        e_we = bus.we[4*win +: 4];
        e_a  = bus.addr[A_W*win +: A_W];
        e_d  = bus.wdata[D_W*win +: D_W];
      end
      check("gnt", bus.gnt, (win >= 0) ? (64'd1 << win) : 64'd0);
      check("fsm_locked", dbg_locked, m_locked);
      check("ram_en", bus.ram_en, win >= 0);
      check("ram_we", bus.ram_we, e_we);
      check("ram_a", bus.ram_a, e_a);
      check("ram_di", bus.ram_di, e_d);
      if (win >= 0) begin
        if (e_we == 4'b0000) exp_q.push_back('{win, ref_mem[e_a], cyc + 1});
        else
          for (int b = 0; b < 4; b++)
            if (e_we[b]) ref_mem[e_a][8*b +: 8] = e_d[8*b +: 8];
        if (bus.lock[win]) begin
          m_locked = 1'b1; m_owner = win;
        end else begin
          m_locked = 1'b0; m_ptr = (win + 1) % NREQ;
        end
      end else if (m_locked && open) begin
        m_locked = 1'b0; m_ptr = (m_owner + 1) % NREQ;
      end
    end
  end

  // ---------------- monitor: read return ----------------
  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) begin
      check("rvalid_in_reset", bus.rvalid, 0);
    end else if (bus.rvalid != '0) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rvalid_unexpected: got rvalid=%b expected none (cycle %0d)", bus.rvalid, cyc);
      end else begin
        e = exp_q.pop_front();
        check("rvalid_tag", bus.rvalid, 64'd1 << e.tag);
        check("rdata", bus.rdata, e.data);
        check("rvalid_latency", cyc, e.due);
      end
    end else begin
      check("rdata_idle", bus.rdata, 0);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        checks++; errors++;
        $display("FAIL rvalid_missing: got none expected tag %0d (cycle %0d)", exp_q[0].tag, cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [NREQ-1:0] gnt_seen = '0;
  always @(negedge CLK) gnt_seen = bus.gnt;

  task automatic cycle();
    @(posedge CLK); #1;
  endtask

  task automatic set_slot(input int i, input logic r, input logic l, input logic [3:0] w,
                          input logic [A_W-1:0] a, input logic [D_W-1:0] d);
    bus.req[i]                = r;
    bus.lock[i]               = l;
    bus.we[4*i +: 4]          = w;
    bus.addr[A_W*i +: A_W]    = a;
    bus.wdata[D_W*i +: D_W]   = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) set_slot(i, 1'b0, 1'b0, 4'b0, '0, '0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    cycle(); cycle();
    RST_N = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  bit pend [NREQ];

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      ram_mem[a] = $urandom;
      ref_mem[a] = ram_mem[a];
    end
    bus.ram_do = '0;
    clear_all();
    cycle(); cycle(); cycle();
    RST_N = 1'b1;

    // single read of word 5
    set_slot(0, 1'b1, 1'b0, 4'b0, 9'h005, '0);
    cycle();
    clear_all();
    cycle(); cycle();

    // contention from ptr=0: alternate 01,10,01,10
    do_reset();
    set_slot(0, 1'b1, 1'b0, 4'b0, 9'd1, '0);
    set_slot(1, 1'b1, 1'b0, 4'b0, 9'd2, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("contention_order", bus.gnt, (k % 2 == 0) ? 64'd1 : 64'd2);
      cycle();
    end
    clear_all();
    cycle();

    // byte-lane write then read back by requester 1
    set_slot(1, 1'b1, 1'b0, 4'b0010, 9'd3, 32'h0000AB00);
    cycle();
    set_slot(1, 1'b1, 1'b0, 4'b0000, 9'd3, '0);
    cycle();
    clear_all();
    cycle();

    // locked burst of three reads while requester 1 waits
    set_slot(1, 1'b1, 1'b0, 4'b0, 9'd20, '0);
    set_slot(0, 1'b1, 1'b1, 4'b0, 9'd10, '0); cycle();
    set_slot(0, 1'b1, 1'b1, 4'b0, 9'd11, '0); cycle();
    set_slot(0, 1'b1, 1'b0, 4'b0, 9'd12, '0); cycle();
    set_slot(0, 1'b0, 1'b0, 4'b0, '0, '0);
    @(negedge CLK);
    check("burst_then_waiter", bus.gnt, 64'd2);
    cycle();
    clear_all();
    cycle();

    // owner abandons lock; waiting requester 1 granted the same cycle
    set_slot(0, 1'b1, 1'b1, 4'b0, 9'd7, '0);
    cycle();
    set_slot(0, 1'b0, 1'b0, 4'b0, '0, '0);
    set_slot(1, 1'b1, 1'b0, 4'b0, 9'd8, '0);
    @(negedge CLK);
    check("abandon_grant", bus.gnt, 64'd2);
    cycle();
    clear_all();
    cycle();

    // reset in the cycle after a read grant
    set_slot(1, 1'b1, 1'b0, 4'b0, 9'd30, '0);
    cycle();
    cycle();
    set_slot(0, 1'b1, 1'b0, 4'b0, 9'd31, '0);
    set_slot(1, 1'b0, 1'b0, 4'b0, '0, '0);
    cycle();
    RST_N = 1'b0;
    clear_all();
    @(negedge CLK);
    check("rvalid_dropped", bus.rvalid, 0);
    cycle();
    RST_N = 1'b1;
    set_slot(0, 1'b1, 1'b0, 4'b0, 9'd32, '0);
    set_slot(1, 1'b1, 1'b0, 4'b0, 9'd33, '0);
    @(negedge CLK);
    check("post_reset_first", bus.gnt, 64'd1);
    cycle();
    clear_all();
    cycle();

    // randomized traffic; each requester holds its request until granted
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] || gnt_seen[i]) begin
          pend[i] = ($urandom_range(0, 99) < 60);
          if (pend[i])
            set_slot(i, 1'b1, ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)),
                     9'($urandom_range(0, 15)), $urandom);
          else
            set_slot(i, 1'b0, ($urandom_range(0, 3) == 0), 4'b0, '0, '0);
        end
      end
      cycle();
    end

    clear_all();
    cycle(); cycle(); cycle();
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
